mem_unit: RTL

- Parametrised multicycle memory stage for the CPU datapath: selects instruction (PC) or data (ALUOut) address, performs byte/half/word loads and stores with sign/zero extension, and latches the instruction register.
- Adds a request/ready handshake with configurable wait states, replacing the fixed single-cycle access.
- The multicycle control FSM holds MemRead/MemWrite until mem_ready, then advances.
- Misaligned accesses are reported through mem_err.

---
 rtl/cpu_mem_pkg.sv | 64 ++++++
 rtl/mem_ram_sp.sv | 23 ++
 rtl/mem_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared encodings and lane helpers for the multicycle memory stage.
// Lane helpers assume a 32-bit datapath with four byte lanes.
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  function automatic logic [3:0] byte_en(
    input logic [1:0] sz,
    input logic [1:0] lane
  );
    unique case (sz)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] lane
  );
    unique case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] wr_rep(
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    unique case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] word,
    input logic [1:0]  sz,
    input logic [1:0]  lane,
    input logic        sx
  );
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    unique case (sz)
      SZ_BYTE: return {{24{sx & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sx & sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous RAM with byte write enables and registered read.
// Contents are not reset.
module mem_ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_unit.sv
// Multicycle memory stage: address select, sub-word load/store,
// request/ready handshake with wait states, misalignment reporting.
module mem_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       PC,
  input  logic [31:0]       ALUOut,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] dataout,
  output logic [DATA_W-1:0] IR,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam logic [2:0] WLAST =
    (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  state_t state, nxt;
  logic [2:0] cnt;
  logic [ADDR_W-1:0] a_idx;
  logic [1:0] a_lane, a_size;
  logic a_sx, a_irw, a_wr, a_err;
  logic [DATA_W-1:0] a_wd;

  logic [31:0] addr;
  logic req, bad, fin;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0] ram_we;
  logic [DATA_W-1:0] ram_wd, ram_q;
  logic unused;

  assign addr   = IorD ? ALUOut : PC;
  assign req    = MemRead | MemWrite;
  assign bad    = misaligned(size, addr[1:0]);
  assign unused = ^addr[31:ADDR_W+2];

  // RAM reads every cycle; in IDLE it follows the live address so the
  // word is already in ram_q by the end of ACCESS.
  assign ram_addr = (state == IDLE) ? addr[ADDR_W+1:2] : a_idx;
  assign ram_wd   = wr_rep(a_size, a_wd);
  assign ram_we   = (state == ACCESS && a_wr && rst_n)
                  ? byte_en(a_size, a_lane) : 4'b0000;

  assign mem_ready = (state == DONE);
  assign mem_err   = (state == DONE) && a_err;

  always_comb begin
    nxt = state;
    fin = 1'b0;
    unique case (state)
      IDLE: if (req) nxt = bad ? DONE : ACCESS;
      ACCESS: begin
        if (WAIT_CYCLES == 0) begin
          nxt = DONE;
          fin = 1'b1;
        end else begin
          nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == WLAST) begin
          nxt = DONE;
          fin = 1'b1;
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      IR      <= '0;
      dataout <= '0;
      a_idx   <= '0;
      a_lane  <= 2'b00;
      a_size  <= SZ_BYTE;
      a_sx    <= 1'b0;
      a_irw   <= 1'b0;
      a_wr    <= 1'b0;
      a_err   <= 1'b0;
      a_wd    <= '0;
    end else begin
      state <= nxt;
      cnt   <= (state == WAIT) ? cnt + 3'd1 : 3'd0;
      if (state == IDLE && req) begin
        a_idx  <= addr[ADDR_W+1:2];
        a_lane <= addr[1:0];
        a_size <= size;
        a_sx   <= sign_ext;
        a_irw  <= IRWrite;
        a_wr   <= MemWrite;
        a_err  <= bad;
        a_wd   <= wdata;
      end
      if (fin && !a_wr) begin
        dataout <= load_ext(ram_q, a_size, a_lane, a_sx);
        if (a_irw) IR <= ram_q;
      end
    end
  end

  mem_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wd),
    .rdata (ram_q)
  );

endmodule
